cdb_scheduler: RTL and testbench
================================

Name: cdb_scheduler

Overview:
- Sequential writeback scheduler that shares the NUM_CDB common data bus ports among NUM_REQ functional-unit result producers (ALUs, branch unit, LSU load return).
- Each requester gets a one-entry holding register.
- Each cycle, up to NUM_CDB held results are granted: oldest-first relative to the ROB head, with anti-starvation promotion.
- Granted results drive registered CDB outputs consumed by the reservation stations, the ROB and the LSQ.

Parameters:
- NUM_REQ, 4, number of result producers.
- NUM_CDB, 2, number of CDB broadcast ports.
- TAG_WIDTH, 6, ROB tag width.
- DATA_WIDTH, 32, result width.
- STARVE_LIMIT, 3, cycles waited (without grant) after which an entry is promoted.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-low reset (0 = reset).
- flush  in  1  pipeline flush from ROB.
- rob_head  in  TAG_WIDTH  current ROB head tag.
- req_val  in  NUM_REQ  per-requester result valid.
- req_rdy  out  NUM_REQ  per-requester holding register can accept.
- req_tag  in  NUM_REQ*TAG_WIDTH  per-requester ROB tag, requester i at bits [i*TAG_WIDTH +: TAG_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester result, same packing.
- cdb_val  out  NUM_CDB  CDB port valid.
- cdb_tag  out  NUM_CDB*TAG_WIDTH  CDB port tag.
- cdb_data  out  NUM_CDB*DATA_WIDTH  CDB port data.
- cdb_src  out  NUM_CDB*$clog2(NUM_REQ)  index of the requester driving each port.

Behaviour:
- Reset (rst=0, asynchronous): all hold_val, wait_cnt, cdb_val, cdb_tag, cdb_data and cdb_src clear to 0. req_rdy is combinational; it is all-ones during reset because no entries are held.
- Holding entry i contains hold_val, hold_tag, hold_data and wait_cnt (width clog2(STARVE_LIMIT+1)).
- Handshake:
  - req_rdy[i] = !flush && (!hold_val[i] || grant[i]).
  - Transfer occurs when req_val[i] && req_rdy[i]; the entry loads at the next edge and wait_cnt resets to 0.
  - A requester may hold req_val with stable data while req_rdy=0.
- Grant (combinational, on held entries only):
  - age_i = (hold_tag_i - rob_head) mod 2^TAG_WIDTH; smaller value is older.
  - Class A = held entries with wait_cnt == STARVE_LIMIT; class B = all other held entries.
  - Select up to NUM_CDB entries: all of class A before any of class B; within a class, oldest first; on equal age, lower index wins.
  - The k-th selected entry goes to CDB port k. Unused ports have cdb_val=0.
- Output register:
  - At the edge, cdb_* load the selected entries.
  - Latency: handshake accepted in cycle n gives earliest cdb_val in cycle n+2.
  - Output is held for exactly one cycle; there is no backpressure from consumers.
- Holding update at the edge:
  - Granted entry: cleared, or reloaded if a same-cycle transfer occurs (back-to-back, full throughput per requester).
  - Held and not granted: wait_cnt saturates at STARVE_LIMIT.
- Flush:
  - At the edge, clears all hold_val and wait_cnt and drives cdb_val to 0.
  - Inputs presented during the flush cycle are not accepted (req_rdy=0).
  - Outputs already on the CDB in the flush cycle are unaffected in that cycle.
- Boundary conditions:
  - Zero held entries: all cdb_val=0.
  - More than NUM_CDB entries held: excess entries wait and accumulate wait_cnt.
  - Tag wrap: handled by the modular subtraction, e.g. rob_head=62, tag 1 is older than tag 5, and tag 63 is older than both.
  - rob_head changes only shift priority; they never drop an entry.
- Invariants:
  - No tag is broadcast twice.
  - No two ports carry the same source in one cycle.
  - cdb_src matches the source of the data.

Test Plan:
- Reset then single result: after rst deasserts, req 0 sends tag=5, data=0xAAAA5555 in cycle 0 -> cdb_val[0]=1, tag=5, src=0 in cycle 2; cdb_val[1]=0; req_rdy[0]=1 throughout.
- Age ordering with wrap: rob_head=62, reqs 0..3 send tags 5, 1, 63, 10 in the same cycle -> cycle 2: port0=tag 63 (src 2), port1=tag 1 (src 1); cycle 3: port0=tag 5, port1=tag 10.
- Starvation promotion: rob_head=0; req 3 holds tag 40; reqs 0..2 stream tags 1..N every cycle, always older -> req 3 is granted exactly after wait_cnt reaches 3, appearing on port0 in cycle 5 ahead of younger class-B entries.
- Backpressure/throughput: all 4 requesters assert req_val continuously -> aggregate 2 results/cycle; req_rdy toggles only for non-granted entries; no tag lost or duplicated over 100 cycles (scoreboard).
- Flush mid-operation: 3 entries held, flush=1 for one cycle while req 1 presents tag 9 -> req_rdy=0 that cycle; next cycle all cdb_val=0 and no held entry survives; tag 9 is never broadcast.
- Async reset mid-stream: rst driven 0 between edges with entries held -> cdb_val immediately 0 and holding cleared; normal operation resumes after release.

Source files
------------

// File: rtl/cdb_scheduler.sv
// cdb_scheduler: shares NUM_CDB result-broadcast ports among NUM_REQ
// functional-unit producers, oldest-first with starvation promotion.
//
// Ports:
//   clk, rst            core clock, async active-low reset
//   flush, rob_head     ROB flush and current head tag
//   req_val/rdy/tag/data  per-requester result handshake (packed by index)
//   cdb_val/tag/data/src  registered broadcast ports (packed by port)
module cdb_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_CDB      = 2,
    parameter int TAG_WIDTH    = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [TAG_WIDTH-1:0]                rob_head,
    input  logic [NUM_REQ-1:0]                  req_val,
    output logic [NUM_REQ-1:0]                  req_rdy,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]        req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_data,
    output logic [NUM_CDB-1:0]                  cdb_val,
    output logic [NUM_CDB*TAG_WIDTH-1:0]        cdb_tag,
    output logic [NUM_CDB*DATA_WIDTH-1:0]       cdb_data,
    output logic [NUM_CDB*$clog2(NUM_REQ)-1:0]  cdb_src
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int KEY_W = 1 + TAG_WIDTH + SRC_W;

    // holding registers
    logic [NUM_REQ-1:0]    hold_val_q, hold_val_d;
    logic [TAG_WIDTH-1:0]  hold_tag_q  [NUM_REQ];
    logic [TAG_WIDTH-1:0]  hold_tag_d  [NUM_REQ];
    logic [DATA_WIDTH-1:0] hold_data_q [NUM_REQ];
    logic [DATA_WIDTH-1:0] hold_data_d [NUM_REQ];
    logic [CNT_W-1:0]      wait_cnt_q  [NUM_REQ];
    logic [CNT_W-1:0]      wait_cnt_d  [NUM_REQ];

    // output registers
    logic [NUM_CDB-1:0]    cdb_val_q, cdb_val_d;
    logic [TAG_WIDTH-1:0]  cdb_tag_q  [NUM_CDB];
    logic [TAG_WIDTH-1:0]  cdb_tag_d  [NUM_CDB];
    logic [DATA_WIDTH-1:0] cdb_data_q [NUM_CDB];
    logic [DATA_WIDTH-1:0] cdb_data_d [NUM_CDB];
    logic [SRC_W-1:0]      cdb_src_q  [NUM_CDB];
    logic [SRC_W-1:0]      cdb_src_d  [NUM_CDB];

    // arbitration
    logic [KEY_W-1:0]      key [NUM_REQ];
    logic [TAG_WIDTH-1:0]  age [NUM_REQ];
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_CDB-1:0]    sel_val;
    logic [SRC_W-1:0]      sel_idx [NUM_CDB];
    logic                  found;
    logic [KEY_W-1:0]      best_key;
    logic [SRC_W-1:0]      best;
    logic [NUM_REQ-1:0]    xfer;

    // Priority key: promoted entries first, then age from ROB head,
    // then index. Keys are unique, so a strict min gives all tie-breaks.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            age[i] = hold_tag_q[i] - rob_head;
            key[i] = {wait_cnt_q[i] != CNT_W'(STARVE_LIMIT), age[i], SRC_W'(i)};
        end
    end

    // Port k takes the best entry not already taken by ports 0..k-1.
    always_comb begin
        grant    = '0;
        sel_val  = '0;
        found    = 1'b0;
        best_key = '1;
        best     = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            sel_idx[k] = '0;
        end
        for (int k = 0; k < NUM_CDB; k++) begin
            found    = 1'b0;
            best_key = '1;
            best     = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hold_val_q[i] && !grant[i] && (!found || key[i] < best_key)) begin
                    found    = 1'b1;
                    best_key = key[i];
                    best     = SRC_W'(i);
                end
            end
            if (found) begin
                grant[best] = 1'b1;
                sel_val[k]  = 1'b1;
                sel_idx[k]  = best;
            end
        end
    end

    assign req_rdy = {NUM_REQ{!flush}} & (~hold_val_q | grant);
    assign xfer    = req_val & req_rdy;

    always_comb begin
        hold_val_d = hold_val_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            hold_tag_d[i]  = hold_tag_q[i];
            hold_data_d[i] = hold_data_q[i];
            wait_cnt_d[i]  = wait_cnt_q[i];
            if (flush) begin
                hold_val_d[i] = 1'b0;
                wait_cnt_d[i] = '0;
            end else if (xfer[i]) begin
                hold_val_d[i]  = 1'b1;
                hold_tag_d[i]  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
                hold_data_d[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                wait_cnt_d[i]  = '0;
            end else if (grant[i]) begin
                hold_val_d[i] = 1'b0;
                wait_cnt_d[i] = '0;
            end else if (hold_val_q[i] && wait_cnt_q[i] != CNT_W'(STARVE_LIMIT)) begin
                wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CDB; k++) begin
            cdb_val_d[k]  = sel_val[k] && !flush;
            cdb_tag_d[k]  = cdb_val_d[k] ? hold_tag_q[sel_idx[k]]  : '0;
            cdb_data_d[k] = cdb_val_d[k] ? hold_data_q[sel_idx[k]] : '0;
            cdb_src_d[k]  = cdb_val_d[k] ? sel_idx[k]              : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_val_q <= '0;
            cdb_val_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_tag_q[i]  <= '0;
                hold_data_q[i] <= '0;
                wait_cnt_q[i]  <= '0;
            end
            for (int k = 0; k < NUM_CDB; k++) begin
                cdb_tag_q[k]  <= '0;
                cdb_data_q[k] <= '0;
                cdb_src_q[k]  <= '0;
            end
        end else begin
            hold_val_q <= hold_val_d;
            cdb_val_q  <= cdb_val_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_tag_q[i]  <= hold_tag_d[i];
                hold_data_q[i] <= hold_data_d[i];
                wait_cnt_q[i]  <= wait_cnt_d[i];
            end
            for (int k = 0; k < NUM_CDB; k++) begin
                cdb_tag_q[k]  <= cdb_tag_d[k];
                cdb_data_q[k] <= cdb_data_d[k];
                cdb_src_q[k]  <= cdb_src_d[k];
            end
        end
    end

    always_comb begin
        cdb_val = cdb_val_q;
        for (int k = 0; k < NUM_CDB; k++) begin
            cdb_tag[k*TAG_WIDTH +: TAG_WIDTH]    = cdb_tag_q[k];
            cdb_data[k*DATA_WIDTH +: DATA_WIDTH] = cdb_data_q[k];
            cdb_src[k*SRC_W +: SRC_W]            = cdb_src_q[k];
        end
    end

endmodule

// File: tb/tb_cdb_scheduler.sv
// tb_cdb_scheduler: directed bench for cdb_scheduler (4 requesters,
// 2 ports, 6-bit tags) with a per-source scoreboard for the stream phase.
module tb_cdb_scheduler;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [5:0]   rob_head;
    logic [3:0]   req_val;
    logic [3:0]   req_rdy;
    logic [23:0]  req_tag;
    logic [127:0] req_data;
    logic [1:0]   cdb_val;
    logic [11:0]  cdb_tag;
    logic [63:0]  cdb_data;
    logic [3:0]   cdb_src;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  src;
        logic [5:0]  tag;
        logic [31:0] data;
    } ent_t;

    ent_t sb[$];

    int st_tag [8] = '{1, 2, 3, 4, 5, 6, 40, 7};
    int st_src [8] = '{0, 1, 2, 0, 1, 2, 3, 0};

    cdb_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .rob_head (rob_head),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_tag  (req_tag),
        .req_data (req_data),
        .cdb_val  (cdb_val),
        .cdb_tag  (cdb_tag),
        .cdb_data (cdb_data),
        .cdb_src  (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout observed no_finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [5:0] t, input logic [31:0] d);
        req_tag[i*6 +: 6]   = t;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic chk_port(input string nm, input int k, input int t, input int s);
        chk({nm, "_val"}, 64'(cdb_val[k]), 64'd1);
        chk({nm, "_tag"}, 64'(cdb_tag[k*6 +: 6]), 64'(t));
        chk({nm, "_src"}, 64'(cdb_src[k*2 +: 2]), 64'(s));
    endtask

    task automatic drain();
        req_val = '0;
        flush   = 1'b0;
        repeat (6) nxt();
    endtask

    // Match each broadcast against the oldest outstanding entry of its source.
    task automatic sb_check();
        int hit;
        for (int k = 0; k < 2; k++) begin
            if (cdb_val[k]) begin
                hit = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (hit < 0 && sb[j].src == cdb_src[k*2 +: 2]) hit = j;
                end
                chk("sb_hit", 64'(hit >= 0), 64'd1);
                if (hit >= 0) begin
                    chk("sb_tag", 64'(cdb_tag[k*6 +: 6]), 64'(sb[hit].tag));
                    chk("sb_data", 64'(cdb_data[k*32 +: 32]), 64'(sb[hit].data));
                    sb.delete(hit);
                end
            end
        end
        if (cdb_val == 2'b11) begin
            chk("src_distinct", 64'(cdb_src[1:0] != cdb_src[3:2]), 64'd1);
        end
    endtask

    initial begin
        logic [3:0] xf;
        int nt;
        int outs;
        logic [31:0] cnt;

        rst      = 1'b0;
        flush    = 1'b0;
        rob_head = '0;
        req_val  = '0;
        req_tag  = '0;
        req_data = '0;

        // reset state
        #3;
        chk("rst_cdb_val", 64'(cdb_val), 64'd0);
        chk("rst_rdy", 64'(req_rdy), 64'hF);
        chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
        chk("rst_cdb_src", 64'(cdb_src), 64'd0);
        chk("rst_cdb_data", cdb_data, 64'd0);
        nxt();
        rst = 1'b1;

        // single result, latency 2
        req_val = 4'b0001;
        set_req(0, 6'd5, 32'hAAAA5555);
        mid();
        chk("t1_rdy0", 64'(req_rdy), 64'hF);
        nxt();
        req_val = '0;
        mid();
        chk("t1_c1_val", 64'(cdb_val), 64'd0);
        chk("t1_c1_rdy", 64'(req_rdy), 64'hF);
        nxt();
        mid();
        chk("t1_c2_val", 64'(cdb_val), 64'b01);
        chk_port("t1_c2", 0, 5, 0);
        chk("t1_c2_data", 64'(cdb_data[31:0]), 64'hAAAA5555);
        nxt();
        mid();
        chk("t1_c3_val", 64'(cdb_val), 64'd0);
        drain();

        // age ordering across tag wrap
        rob_head = 6'd62;
        req_val  = 4'hF;
        set_req(0, 6'd5, 32'h100);
        set_req(1, 6'd1, 32'h101);
        set_req(2, 6'd63, 32'h102);
        set_req(3, 6'd10, 32'h103);
        nxt();
        req_val = '0;
        nxt();
        mid();
        chk_port("t2_c2_p0", 0, 63, 2);
        chk_port("t2_c2_p1", 1, 1, 1);
        chk("t2_c2_d0", 64'(cdb_data[31:0]), 64'h102);
        nxt();
        mid();
        chk_port("t2_c3_p0", 0, 5, 0);
        chk_port("t2_c3_p1", 1, 10, 3);
        nxt();
        mid();
        chk("t2_c4_val", 64'(cdb_val), 64'd0);
        drain();

        // starvation promotion
        rob_head = '0;
        req_val  = 4'hF;
        set_req(0, 6'd1, 32'd1);
        set_req(1, 6'd2, 32'd2);
        set_req(2, 6'd3, 32'd3);
        set_req(3, 6'd40, 32'd40);
        nt = 4;
        for (int c = 0; c < 6; c++) begin
            mid();
            if (c >= 2) begin
                chk_port($sformatf("t3_c%0d_p0", c), 0, st_tag[(c-2)*2], st_src[(c-2)*2]);
                chk_port($sformatf("t3_c%0d_p1", c), 1, st_tag[(c-2)*2+1], st_src[(c-2)*2+1]);
            end
            xf = req_val & req_rdy;
            nxt();
            if (c == 0) req_val[3] = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (xf[i]) begin
                    set_req(i, 6'(nt), 32'(nt));
                    nt++;
                end
            end
        end
        drain();

        // full-load throughput with scoreboard
        rob_head = 6'd17;
        cnt  = 0;
        outs = 0;
        for (int i = 0; i < 4; i++) begin
            set_req(i, cnt[5:0], 32'hC000_0000 | cnt);
            cnt++;
        end
        req_val = 4'hF;
        for (int c = 0; c < 100; c++) begin
            mid();
            if (c >= 2) begin
                chk("t4_both_val", 64'(cdb_val), 64'b11);
                outs += int'(cdb_val[0]) + int'(cdb_val[1]);
            end
            sb_check();
            xf = req_val & req_rdy;
            for (int i = 0; i < 4; i++) begin
                if (xf[i]) sb.push_back({2'(i), req_tag[i*6 +: 6], req_data[i*32 +: 32]});
            end
            nxt();
            for (int i = 0; i < 4; i++) begin
                if (xf[i]) begin
                    set_req(i, cnt[5:0], 32'hC000_0000 | cnt);
                    cnt++;
                end
            end
        end
        req_val = '0;
        for (int c = 0; c < 6; c++) begin
            mid();
            sb_check();
            nxt();
        end
        chk("t4_outs", 64'(outs), 64'd196);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);
        drain();

        // flush mid-operation
        rob_head = '0;
        req_val  = 4'b0001;
        set_req(0, 6'd30, 32'h30);
        nxt();
        req_val = 4'b1110;
        set_req(1, 6'd20, 32'h20);
        set_req(2, 6'd21, 32'h21);
        set_req(3, 6'd22, 32'h22);
        nxt();
        req_val = 4'b0010;
        set_req(1, 6'd9, 32'h9);
        flush = 1'b1;
        mid();
        chk("t5_flush_rdy", 64'(req_rdy), 64'd0);
        chk("t5_c1_val", 64'(cdb_val), 64'b01);
        chk("t5_c1_tag", 64'(cdb_tag[5:0]), 64'd30);
        nxt();
        flush   = 1'b0;
        req_val = '0;
        mid();
        chk("t5_c2_val", 64'(cdb_val), 64'd0);
        chk("t5_c2_rdy", 64'(req_rdy), 64'hF);
        nxt();
        mid();
        chk("t5_c3_val", 64'(cdb_val), 64'd0);
        nxt();
        mid();
        chk("t5_c4_val", 64'(cdb_val), 64'd0);
        drain();

        // async reset mid-stream
        req_val = 4'hF;
        set_req(0, 6'd11, 32'h11);
        set_req(1, 6'd12, 32'h12);
        set_req(2, 6'd13, 32'h13);
        set_req(3, 6'd14, 32'h14);
        nxt();
        req_val = '0;
        mid();
        chk("t6_c1_val", 64'(cdb_val), 64'd0);
        nxt();
        mid();
        chk("t6_c2_val", 64'(cdb_val), 64'b11);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_arst_val", 64'(cdb_val), 64'd0);
        chk("t6_arst_rdy", 64'(req_rdy), 64'hF);
        chk("t6_arst_tag", 64'(cdb_tag), 64'd0);
        nxt();
        rst     = 1'b1;
        req_val = 4'b0100;
        set_req(2, 6'd33, 32'h33);
        mid();
        chk("t6_r_rdy", 64'(req_rdy), 64'hF);
        nxt();
        req_val = '0;
        mid();
        chk("t6_r1_val", 64'(cdb_val), 64'd0);
        nxt();
        mid();
        chk("t6_r2_val", 64'(cdb_val), 64'b01);
        chk_port("t6_r2", 0, 33, 2);
        nxt();
        mid();
        chk("t6_r3_val", 64'(cdb_val), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
